// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage (XLEN, slot states, PC stepping).
// Pure declarations: no latency, no flow control.
package fetch_unit_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    SLOT_EMPTY   = 2'd0,
    SLOT_PENDING = 2'd1,
    SLOT_FULL    = 2'd2
  } slot_state_t;

  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(INSTR_BYTES);
  endfunction

endpackage

// File: rtl/fetch_slot_buf.sv
// In-order slot ring pairing each fetch PC with its returned word; alloc/fill/pop/flush update in one cycle.
// Back-pressure: has_free is registered-only, so a slot freed by a pop is reusable only on the next cycle.
module fetch_slot_buf
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            alloc,
  input  logic [XLEN-1:0] alloc_pc,
  input  logic            fill,
  input  logic [XLEN-1:0] fill_data,
  input  logic            pop,
  input  logic            flush,
  output logic            has_free,
  output logic            head_full,
  output logic [XLEN-1:0] head_pc,
  output logic [XLEN-1:0] head_data,
  output logic [CW-1:0]   pend_cnt
);

  slot_state_t     state [DEPTH];
  logic [XLEN-1:0] pc_q  [DEPTH];
  logic [XLEN-1:0] dat_q [DEPTH];
  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;
  logic [AW-1:0]   pend;
  logic [CW-1:0]   count;

  assign has_free  = (count != CW'(DEPTH));
  assign head_full = (state[head] == SLOT_FULL);
  assign head_pc   = pc_q[head];
  assign head_data = dat_q[head];

  // tail (alloc), pend (fill) and head (pop) always address distinct slots in one cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      pend     <= '0;
      count    <= '0;
      pend_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        state[i] <= SLOT_EMPTY;
        pc_q[i]  <= '0;
        dat_q[i] <= '0;
      end
    end else if (flush) begin
      head     <= '0;
      tail     <= '0;
      pend     <= '0;
      count    <= '0;
      pend_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        state[i] <= SLOT_EMPTY;
      end
    end else begin
      if (alloc) begin
        state[tail] <= SLOT_PENDING;
        pc_q[tail]  <= alloc_pc;
        tail        <= tail + AW'(1);
      end
      if (fill) begin
        state[pend] <= SLOT_FULL;
        dat_q[pend] <= fill_data;
        pend        <= pend + AW'(1);
      end
      if (pop) begin
        state[head] <= SLOT_EMPTY;
        head        <= head + AW'(1);
      end
      count    <= count + CW'(alloc) - CW'(pop);
      pend_cnt <= pend_cnt + CW'(alloc) - CW'(fill);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, issues imem requests, drops wrong-path responses; req->instr_valid = L+1 cycles.
// Stalls requests when the buffer is full or drops are outstanding; FETCH_MISALIGN_CHECK_EN adds a sticky fetch_fault.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int              IBUF_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instruction,
  output logic [XLEN-1:0] PC
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic            fetch_fault
`endif
);

  localparam int CW = $clog2(IBUF_DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] redirect_pc;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   pend_cnt;
  logic            has_free;
  logic            head_full;
  logic            req_fire;
  logic            rsp_drop;
  logic            rsp_fill;
  logic            pop;
  logic            fault_q;

  assign imem_req_valid = !reset && has_free && (drop_cnt == '0) && !fault_q;
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_drop       = imem_rsp_valid && (drop_cnt != '0);
  assign rsp_fill       = imem_rsp_valid && (drop_cnt == '0) && !branch_taken;
  assign instr_valid    = head_full;
  assign pop            = instr_valid && instr_ready;
  assign redirect_pc    = {branch_target[XLEN-1:2], 2'b00};

  // A redirect turns every in-flight request, including one firing now, into a response to drop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      drop_cnt <= '0;
    end else if (branch_taken) begin
      fetch_pc <= redirect_pc;
      drop_cnt <= drop_cnt + pend_cnt + CW'(req_fire) - CW'(imem_rsp_valid);
    end else begin
      if (req_fire) fetch_pc <= next_pc(fetch_pc);
      if (rsp_drop) drop_cnt <= drop_cnt - CW'(1);
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fault_q <= 1'b0;
    end else if (branch_taken && (branch_target[1:0] != 2'b00)) begin
      fault_q <= 1'b1;
    end
  end
  assign fetch_fault = fault_q;
`else
  logic unused_target_lsbs;
  assign unused_target_lsbs = ^branch_target[1:0];
  assign fault_q = 1'b0;
`endif

  fetch_slot_buf #(
    .DEPTH(IBUF_DEPTH)
  ) u_slot_buf (
    .clk      (clk),
    .reset    (reset),
    .alloc    (req_fire && !branch_taken),
    .alloc_pc (fetch_pc),
    .fill     (rsp_fill),
    .fill_data(imem_rsp_data),
    .pop      (pop),
    .flush    (branch_taken),
    .has_free (has_free),
    .head_full(head_full),
    .head_pc  (PC),
    .head_data(instruction),
    .pend_cnt (pend_cnt)
  );

  rsp_has_owner: assert property (@(posedge clk) disable iff (reset)
    (imem_rsp_valid && (drop_cnt == '0)) |-> (pend_cnt != '0));

endmodule

// File: doc/fetch_unit.md
# fetch_unit

- Instruction-fetch stage directly upstream of the datapath.
- Owns the architectural PC and issues word fetches to instruction memory over a valid/ready request channel.
- Buffers in-order responses, each paired with its PC, and presents them to the datapath as `instruction`/`PC` with a valid/ready handshake.
- Redirects to the datapath's `BranchTarget` on a taken branch, discarding wrong-path state.

## Interface

Parameters:
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `IBUF_DEPTH`, default 4: instruction buffer slots; power of two, ≥2.

Ports:
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `imem_req_valid` output 1: fetch request valid.
- `imem_req_ready` input 1: memory accepts request.
- `imem_req_addr` output 32: word-aligned fetch address.
- `imem_rsp_valid` input 1: response valid; responses return in request order, latency ≥1 cycle, never back-pressured.
- `imem_rsp_data` input 32: fetched instruction word.
- `branch_taken` input 1: redirect request (Branch & Zero from datapath).
- `branch_target` input 32: redirect address.
- `instr_valid` output 1: `instruction`/`PC` valid.
- `instr_ready` input 1: datapath consumes.
- `instruction` output 32: buffered instruction word.
- `PC` output 32: address of `instruction`.
- `fetch_fault` output 1: only with `FETCH_MISALIGN_CHECK_EN`; sticky misaligned-redirect flag.

## Operation

- Reset values:
  - `fetch_pc` = `RESET_PC`.
  - All slots empty.
  - `drop_cnt` = 0.
  - `imem_req_valid` = 0; `imem_req_addr` = `RESET_PC`.
  - `instr_valid` = 0; `instruction` = 0; `PC` = 0.
  - `fetch_fault` = 0.
- Circular buffer of `IBUF_DEPTH` slots. Each slot is empty, pending (PC known, awaiting data) or full.
- `imem_req_valid` = (free slot exists) && `drop_cnt` == 0 && !`fetch_fault`. It is derived from registers only; it has no combinational path from `branch_taken` or `imem_rsp_valid`.
- `imem_req_addr` = `fetch_pc`.
- Request fire (valid && ready): allocate tail slot as pending with PC = `fetch_pc`; `fetch_pc` += 4 (mod 2^32, wrap 0xFFFF_FFFC→0).
- Response fire:
  - If `drop_cnt` > 0: decrement `drop_cnt` and discard the data.
  - Otherwise: write the data into the oldest pending slot and mark it full.
  - A response with no pending slot and `drop_cnt` == 0 is illegal (assertion).
- `instr_valid` = head slot full; `instruction`/`PC` come from the head slot. Pop on `instr_valid` && `instr_ready`.
- Redirect, when `branch_taken` is high at an edge:
  - `fetch_pc` ← `branch_target`.
  - All slots are cleared.
  - `drop_cnt` ← `drop_cnt` + pending slots + (request fire this cycle) − (response fire this cycle).
  - A pop in the same cycle completes normally.
  - A request fired in the same cycle is counted as wrong-path.
  - A response in the same cycle is discarded.
- Simultaneous request, response and pop with no redirect all take effect at the same edge. A slot freed by a pop is not reusable until the next cycle.
- Reset asserted mid-operation clears all state immediately. Responses to pre-reset requests are the memory's responsibility to cancel.

## Timing

- First request is presented in the first cycle after reset deasserts.
- Latency: request fire at T, response at T+L (L≥1), `instr_valid` at T+L+1.
- Sustains one instruction/cycle for L=1 with default depth 4. Depth 2 limits throughput to 2/3.
- Redirect at edge E: the request to `branch_target` is issued no earlier than the cycle after E. It waits until `drop_cnt` returns to 0.
- Buffer full (no empty slot): `imem_req_valid` = 0 until a pop.

## Configuration

- `FETCH_MISALIGN_CHECK_EN` defined:
  - `branch_taken` with `branch_target[1:0]` ≠ 0 sets `fetch_fault`, sticky until reset.
  - The redirect still flushes, and fetching stops (`imem_req_valid` = 0).
  - Already-pending wrong-path responses are still dropped.
- Not defined:
  - No `fetch_fault` port.
  - `branch_target[1:0]` is ignored; the redirect uses `{branch_target[31:2], 2'b00}`.

## Structure

- Shared package holds:
  - `XLEN` = 32.
  - `INSTR_BYTES` = 4.
  - `RESET_PC` default constant.
  - The slot-state enum (`SLOT_EMPTY`, `SLOT_PENDING`, `SLOT_FULL`).
- One sub-module: `fetch_slot_buf`, which contains the slot array, head/tail/pending pointers, allocate/fill/pop/flush.
- `fetch_unit` contains the PC register, request gating, drop counter and redirect logic.

## Test plan

- Reset release, memory L=1, `instr_ready`=1:
  - Requests 0x0, 0x4, 0x8… on consecutive cycles.
  - `instr_valid` from cycle 3, one instruction/cycle, `PC` matching the data.
- `instr_ready`=0 for 10 cycles: exactly 4 requests fire, then `imem_req_valid`=0; the first `instr_ready` pop re-enables requests the next cycle.
- L=3 memory, `branch_taken` with target 0x100 while 2 requests are pending:
  - 2 responses are discarded.
  - Next request address is 0x100, issued only after both discards.
  - First delivered `PC`=0x100.
- `branch_taken` in the same cycle as request fire, response fire and pop:
  - The popped instruction is delivered.
  - `drop_cnt` ends at pending+1−1.
  - No wrong-path `PC` reaches the output.
- With `FETCH_MISALIGN_CHECK_EN`, redirect to 0x102: `fetch_fault`=1 next cycle, no further requests, persists until `reset`. Without the macro, the same stimulus fetches 0x100.
- Assert `reset` mid-stream with slots full: `instr_valid`, `imem_req_valid`=0 immediately; after release, fetch restarts at `RESET_PC`.
